// File: rtl/i2c_sub_mem.sv
// I2C subordinate with an embedded byte memory: configurable device address,
// 1- or 2-byte memory addressing, auto-increment with wrap and repeated-START reads.
module i2c_sub_mem #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned ADDR_BYTES = 1,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          busy,
    output logic [PW-1:0] ptr,
    output logic          wr_evt,
    output logic [8:0]    state
);

    typedef enum logic [8:0] {
        S_IDLE     = 9'b0_0000_0001,
        S_DEV_ADDR = 9'b0_0000_0010,
        S_ACK_DEV  = 9'b0_0000_0100,
        S_MEM_ADDR = 9'b0_0000_1000,
        S_ACK_MEM  = 9'b0_0001_0000,
        S_WR_DATA  = 9'b0_0010_0000,
        S_ACK_WR   = 9'b0_0100_0000,
        S_RD_DATA  = 9'b0_1000_0000,
        S_RD_ACK   = 9'b1_0000_0000
    } state_t;

    // Synchronisers reset to the idle-bus level so leaving reset cannot fake an edge.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_hist_q, sda_hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_hist_q <= scl_sync_q[1];
            sda_hist_q <= sda_sync_q[1];
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [7:0]    addr_q, addr_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_evt_q, wr_evt_d;

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte;
    logic [7:0] sr_shift;

    assign rd_byte  = mem[ptr_q];
    assign sr_shift = {sr_q[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (wr_evt_q) begin
            mem[ptr_q] <= sr_q;
        end
    end

    // ACK states use sda_oe_q as their phase: first scl_fall drives, second releases.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        addr_d   = addr_q;
        ptr_d    = wr_evt_q ? ptr_q + 1'b1 : ptr_q;
        sda_oe_d = sda_oe_q;
        busy_d   = busy_q;
        wr_evt_d = 1'b0;

        if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            bit_d    = '0;
        end else if (start_det) begin
            state_d  = S_DEV_ADDR;
            sda_oe_d = 1'b0;
            bit_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                S_DEV_ADDR: begin
                    if (scl_rise) begin
                        sr_d  = sr_shift;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            if (sr_q[6:0] == DEV_ADDR) begin
                                state_d = S_ACK_DEV;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                S_ACK_DEV: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (sr_q[0]) begin
                            state_d  = S_RD_DATA;
                            sr_d     = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                            bit_d    = '0;
                        end else begin
                            state_d  = S_MEM_ADDR;
                            sda_oe_d = 1'b0;
                            byte_d   = '0;
                            bit_d    = '0;
                        end
                    end
                end
                S_MEM_ADDR: begin
                    if (scl_rise) begin
                        sr_d  = sr_shift;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK_MEM;
                            addr_d  = sr_shift;
                            byte_d  = byte_q + 1'b1;
                            if (byte_q == 2'(ADDR_BYTES - 1)) begin
                                ptr_d = PW'({addr_q, sr_shift});
                            end
                        end
                    end
                end
                S_ACK_MEM: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bit_d    = '0;
                            state_d  = (byte_q == 2'(ADDR_BYTES)) ? S_WR_DATA : S_MEM_ADDR;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise) begin
                        sr_d  = sr_shift;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d  = S_ACK_WR;
                            wr_evt_d = 1'b1;
                        end
                    end
                end
                S_ACK_WR: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bit_d    = '0;
                            state_d  = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_q == 3'd7) begin
                            state_d  = S_RD_ACK;
                            sda_oe_d = 1'b0;
                            ptr_d    = ptr_q + 1'b1;
                            bit_d    = '0;
                        end else begin
                            bit_d    = bit_q + 1'b1;
                            sda_oe_d = ~sr_q[6];
                            sr_d     = {sr_q[6:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    // A fall here always follows an ACK rise, since NACK leaves at the rise.
                    if (scl_rise && sda_s) begin
                        state_d  = S_IDLE;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall) begin
                        state_d  = S_RD_DATA;
                        sr_d     = rd_byte;
                        sda_oe_d = ~rd_byte[7];
                        bit_d    = '0;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            addr_q   <= '0;
            ptr_q    <= '0;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            wr_evt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            addr_q   <= addr_d;
            ptr_q    <= ptr_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            wr_evt_q <= wr_evt_d;
        end
    end

    assign sda_oe = sda_oe_q;
    assign busy   = busy_q;
    assign ptr    = ptr_q;
    assign wr_evt = wr_evt_q;
    assign state  = state_q;

endmodule

// File: tb/tb_i2c_sub_mem.sv
// Bench for i2c_sub_mem: two subordinates share one bus (0x50 1-byte/256, 0x52 2-byte/16),
// driven by a behavioural I2C master and checked against a transaction-level memory model.
module tb_i2c_sub_mem;

    localparam int unsigned T = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic m_scl, m_sda, sda_line;
    logic a_oe, a_busy, a_wr, b_oe, b_busy, b_wr;
    logic [7:0] a_ptr;
    logic [3:0] b_ptr;
    logic [8:0] a_state, b_state;

    assign sda_line = m_sda & ~a_oe & ~b_oe;

    i2c_sub_mem #(.DEV_ADDR(7'h50), .ADDR_BYTES(1), .DEPTH(256)) u_a (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(a_oe),
        .busy(a_busy), .ptr(a_ptr), .wr_evt(a_wr), .state(a_state));

    i2c_sub_mem #(.DEV_ADDR(7'h52), .ADDR_BYTES(2), .DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(b_oe),
        .busy(b_busy), .ptr(b_ptr), .wr_evt(b_wr), .state(b_state));

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned wr_a = 0, wr_b = 0, busy_cyc = 0;

    always @(posedge clk) begin
        if (a_wr) wr_a <= wr_a + 1;
        if (b_wr) wr_b <= wr_b + 1;
        if (a_busy || b_busy) busy_cyc <= busy_cyc + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "timeout");
    end

    // Reference model: plain byte arrays with written flags and a pointer per device.
    logic [7:0]  ma [256];
    bit          va [256];
    logic [7:0]  mb [16];
    bit          vb [16];
    int unsigned pa = 0, pb = 0;

    function automatic int unsigned dep(input bit sel);
        return sel ? 16 : 256;
    endfunction

    function automatic int unsigned dut_ptr(input bit sel);
        return sel ? 32'(b_ptr) : 32'(a_ptr);
    endfunction

    function automatic int unsigned wr_cnt(input bit sel);
        return sel ? wr_b : wr_a;
    endfunction

    task automatic set_ptr(input bit sel, input int unsigned v);
        if (sel) pb = v % 16; else pa = v % 256;
    endtask

    task automatic mwrite(input bit sel, input int unsigned a, input logic [7:0] v);
        if (sel) begin mb[a % 16] = v; vb[a % 16] = 1'b1; end
        else begin ma[a % 256] = v; va[a % 256] = 1'b1; end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #T; m_scl = 1'b1; #(2*T); m_sda = 1'b0; #(2*T); m_scl = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #T; m_scl = 1'b1; #(2*T); m_sda = 1'b1; #(2*T);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        m_sda = b; #T; m_scl = 1'b1; #T; s = sda_line; #T; m_scl = 1'b0; #T;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, s);
            d[i] = s;
        end
        i2c_bit(nack, s);
    endtask

    task automatic send_addr(input bit sel, input logic [15:0] addr, output bit ok);
        logic ack;
        ok = 1'b1;
        if (sel) begin send_byte(addr[15:8], ack); ok &= ack; end
        send_byte(addr[7:0], ack); ok &= ack;
    endtask

    task automatic do_write(input bit sel, input logic [15:0] addr, input int unsigned n,
                            input logic [31:0] d, output bit ok);
        logic ack;
        bit   aok;
        i2c_start();
        send_byte(sel ? 8'hA4 : 8'hA0, ack);
        send_addr(sel, addr, aok);
        ok = ack & aok;
        for (int i = 0; i < int'(n); i++) begin
            send_byte(d[31-8*i -: 8], ack);
            ok &= ack;
            mwrite(sel, 32'(addr) + i, d[31-8*i -: 8]);
        end
        i2c_stop();
        set_ptr(sel, 32'(addr) + n);
    endtask

    task automatic do_read(input bit sel, input bit use_addr, input logic [15:0] addr,
                           input int unsigned n);
        logic        ack;
        logic [7:0]  d;
        bit          ok;
        int unsigned p;
        ok = 1'b1;
        i2c_start();
        if (use_addr) begin
            send_byte(sel ? 8'hA4 : 8'hA0, ack); ok &= ack;
            send_addr(sel, addr, ok);
            set_ptr(sel, 32'(addr));
            i2c_start();
        end
        send_byte(sel ? 8'hA5 : 8'hA1, ack); ok &= ack;
        p = sel ? pb : pa;
        for (int i = 0; i < int'(n); i++) begin
            recv_byte(d, i == int'(n) - 1);
            if (sel ? vb[p] : va[p]) chk("rd data", 32'(d), sel ? 32'(mb[p]) : 32'(ma[p]));
            p = (p + 1) % dep(sel);
        end
        chk("rd nack release", sel ? 32'(b_oe) : 32'(a_oe), 0);
        i2c_stop();
        set_ptr(sel, p);
        chk("rd acks", 32'(ok), 1);
        chk("rd ptr", dut_ptr(sel), p);
    endtask

    typedef struct {
        bit          sel;
        logic [15:0] addr;
        int unsigned n;
        logic [31:0] data;
        int unsigned exp_ptr;
    } wvec_t;

    wvec_t tbl [4];

    initial begin
        logic        ack, s;
        bit          ok;
        logic [7:0]  d, db;
        int unsigned w0, b0, n;
        bit          sel;
        int unsigned op;
        logic [15:0] addr;
        logic [31:0] data;

        tbl[0] = '{sel: 1'b0, addr: 16'h0010, n: 3, data: 32'h11223300, exp_ptr: 32'h13};
        tbl[1] = '{sel: 1'b1, addr: 16'h000F, n: 3, data: 32'hAABBCC00, exp_ptr: 32'h2};
        tbl[2] = '{sel: 1'b1, addr: 16'h123F, n: 1, data: 32'h5A000000, exp_ptr: 32'h0};
        tbl[3] = '{sel: 1'b0, addr: 16'h00FF, n: 3, data: 32'h01020300, exp_ptr: 32'h2};

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("reset sda_oe", {31'd0, a_oe} | {31'd0, b_oe}, 0);
        chk("reset busy", {31'd0, a_busy} | {31'd0, b_busy}, 0);
        chk("reset ptr", {24'd0, a_ptr} | {28'd0, b_ptr}, 0);
        chk("reset wr_evt", {31'd0, a_wr} | {31'd0, b_wr}, 0);
        chk("reset state a", 32'(a_state), 32'h1);
        chk("reset state b", 32'(b_state), 32'h1);

        for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt(tbl[i].sel);
            do_write(tbl[i].sel, tbl[i].addr, tbl[i].n, tbl[i].data, ok);
            chk("tbl ack", 32'(ok), 1);
            chk("tbl wr_evt count", wr_cnt(tbl[i].sel) - w0, tbl[i].n);
            chk("tbl ptr", dut_ptr(tbl[i].sel), tbl[i].exp_ptr);
            chk("tbl busy after stop", {31'd0, a_busy} | {31'd0, b_busy}, 0);
        end

        // Random read of 0x11 with repeated START, fixed expected data.
        ok = 1'b1;
        i2c_start();
        send_byte(8'hA0, ack); ok &= ack;
        send_byte(8'h11, ack); ok &= ack;
        i2c_start();
        send_byte(8'hA1, ack); ok &= ack;
        recv_byte(d, 1'b0);
        chk("rr byte0", 32'(d), 32'h22);
        recv_byte(d, 1'b1);
        chk("rr byte1", 32'(d), 32'h33);
        chk("rr release after nack", 32'(a_oe), 0);
        chk("rr state idle", 32'(a_state), 32'h1);
        i2c_stop();
        chk("rr acks", 32'(ok), 1);
        chk("rr ptr", 32'(a_ptr), 32'h13);
        pa = 32'h13;

        do_read(1'b1, 1'b1, 16'h000F, 3);

        // Address mismatch: nobody acknowledges 0x51.
        w0 = wr_a + wr_b; b0 = busy_cyc;
        i2c_start();
        send_byte(8'hA2, ack);
        chk("mm dev ack", 32'(ack), 0);
        send_byte(8'h55, ack);
        chk("mm data ack", 32'(ack), 0);
        i2c_stop();
        chk("mm busy cycles", busy_cyc - b0, 0);
        chk("mm wr_evt", wr_a + wr_b - w0, 0);

        // STOP while SCL is high during the 4th data bit.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h40, ack);
        pa = 32'h40;
        w0 = wr_a;
        i2c_bit(1'b1, s); i2c_bit(1'b0, s); i2c_bit(1'b1, s);
        m_sda = 1'b0; #T; m_scl = 1'b1; #T; m_sda = 1'b1; #(2*T);
        chk("abort state", 32'(a_state), 32'h1);
        chk("abort ptr", 32'(a_ptr), 32'h40);
        chk("abort wr_evt", wr_a - w0, 0);
        chk("abort busy", 32'(a_busy), 0);
        do_write(1'b0, 16'h0040, 1, 32'h77000000, ok);
        chk("post-abort ack", 32'(ok), 1);
        do_read(1'b0, 1'b1, 16'h0040, 1);

        // Reset while the device-address ACK is being driven.
        i2c_start();
        db = 8'hA0;
        for (int i = 7; i >= 0; i--) i2c_bit(db[i], s);
        m_sda = 1'b1; #T; m_scl = 1'b1; #T;
        chk("pre-reset sda_oe", 32'(a_oe), 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid-reset sda_oe", 32'(a_oe), 0);
        chk("mid-reset state", 32'(a_state), 32'h1);
        chk("mid-reset ptr", 32'(a_ptr), 0);
        chk("mid-reset busy", 32'(a_busy), 0);
        #T; m_scl = 1'b0; #T;
        i2c_stop();
        pa = 0; pb = 0;

        for (int k = 0; k < 20; k++) begin
            sel  = 1'($urandom_range(0, 1));
            op   = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            addr = sel ? 16'($urandom) : 16'($urandom_range(0, 31));
            data = $urandom;
            if (op == 0) begin
                w0 = wr_cnt(sel);
                do_write(sel, addr, n, data, ok);
                chk("rnd wr ack", 32'(ok), 1);
                chk("rnd wr_evt count", wr_cnt(sel) - w0, n);
                chk("rnd wr ptr", dut_ptr(sel), sel ? pb : pa);
            end else begin
                do_read(sel, op == 1, addr, n);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
